multicycle_controller: RTL

Sequencing controller for the multicycle RV32I core. It decodes the registered instruction fields and drives every mux select and write enable in the shared datapath: PC, instruction/data memory port, register file, ALU and the immediate extender's `immsrc`. It sits between the instruction register and the datapath, and handshakes with a single shared memory port that may insert wait states.

---
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: decodes the instruction fields and drives datapath selects/enables.
// Optional feature: define MULTICYCLE_CTRL_BNE_EN to let BRANCH take bne (funct3 001) on !zero.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic [1:0] immsrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t r_state;
  state_t w_next;

  function automatic logic [2:0] alu_decode(input logic [6:0] f_op, input logic [2:0] f_f3,
                                            input logic f_f7b5);
    logic [2:0] f_alu;
    case (f_f3)
      3'b000:  f_alu = (f_op[5] & f_f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  f_alu = ALU_SLT;
      3'b110:  f_alu = ALU_OR;
      3'b111:  f_alu = ALU_AND;
      default: f_alu = ALU_ADD;
    endcase
    return f_alu;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f_f3, input logic f_zero);
    logic f_tk;
`ifdef MULTICYCLE_CTRL_BNE_EN
    case (f_f3)
      3'b000:  f_tk = f_zero;
      3'b001:  f_tk = !f_zero;
      default: f_tk = 1'b0;
    endcase
`else
    f_tk = (f_f3 == 3'b000) && f_zero;
`endif
    return f_tk;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECUTER;
          7'b0010011:             w_next = S_EXECUTEI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_MEMWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    case (op)
      7'b0100011: immsrc = 2'b01;
      7'b1100011: immsrc = 2'b10;
      7'b1101111: immsrc = 2'b11;
      default:    immsrc = 2'b00;
    endcase
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      // DECODE precomputes the branch target into ALUOut
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        adrsrc   = 1'b1;
      end
      S_EXECUTER: begin
        alusrca    = 2'b10;
        alucontrol = alu_decode(op, funct3, funct7b5);
      end
      S_EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = alu_decode(op, funct3, funct7b5);
      end
      S_ALUWB:    regwrite = 1'b1;
      S_BRANCH: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        pcwrite    = branch_taken(funct3, zero);
      end
      S_JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
      S_ILLEGAL:  illegal = 1'b1;
      default:    ;
    endcase
    // Reset is asynchronous, so side-effecting strobes must drop in the same cycle it rises
    if (reset) begin
      mem_req  = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = r_state;

endmodule
